fetch_wf_sched: RTL and testbench
=================================

Name: fetch_wf_sched

Overview:
- Parametrised wavefront PC table and fetch scheduler for the compute unit front end.
- Holds up to NUM_WF wavefront slots, each with a PC, a dispatch tag and status bits.
- Each cycle it arbitrates round-robin among eligible slots and issues at most one instruction-buffer fetch request.
- Handles SALU branch redirects using epoch-tagged stale-fetch discard, and retires wavefronts back to the dispatcher.

Parameters:
NUM_WF, 40, number of wavefront slots
WFID_W, 6, slot id width (2^WFID_W >= NUM_WF)
PC_W, 32, PC width
TAG_W, 15, dispatcher wavefront tag width
FETCH_BYTES, 4, PC increment per acknowledged fetch

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
dispatch2cu_wf_dispatch  in  1  new wavefront request
dispatch2cu_wf_tag_dispatch  in  TAG_W  dispatcher tag
dispatch2cu_start_pc_dispatch  in  PC_W  start PC
cu2dispatch_ready  out  1  at least one slot allocatable
wave_reserve_valid  out  1  slot allocated (1-cycle pulse)
wave_reserve_slotid  out  WFID_W  allocated slot
wave_stop_fetch  in  NUM_WF  per-slot fetch hold (1 = hold)
buff_rd_en  out  1  fetch request (1-cycle pulse)
buff_addr  out  PC_W  fetch PC
buff_tag  out  WFID_W+1  {epoch, slotid}
buff_ack  in  1  fetch completed
buff_ack_tag  in  WFID_W+1  tag of completed fetch
fetch_discard  out  1  ack dropped as stale (1-cycle pulse)
salu_branch_en  in  1  branch resolved
salu_branch_wfid  in  WFID_W  branch slot
salu_branch_taken  in  1  branch taken
salu_branch_pc_value  in  PC_W  target PC
issue_wf_done_en  in  1  wavefront ended
issue_wf_done_wf_id  in  WFID_W  ended slot
cu2dispatch_wf_done  out  1  retire pulse
cu2dispatch_wf_tag_done  out  TAG_W  retired tag

Behaviour:
- Reset (rst=0, async):
  - All valid, pending and epoch bits clear; round-robin pointer = 0.
  - All pulse outputs 0; all data outputs 0; cu2dispatch_ready=1.
- Per-slot state: valid, pending (fetch outstanding), epoch (1 bit), pc[PC_W], tag[TAG_W].
- A slot is allocatable iff valid=0 and pending=0.
- Allocation:
  - cu2dispatch_ready is combinational: OR over allocatable slots.
  - On dispatch with ready=1, take the lowest-index allocatable slot, evaluated on pre-edge state.
  - Write pc = start PC, store tag, set valid.
  - Next cycle: wave_reserve_valid=1 and wave_reserve_slotid = that slot.
  - Dispatch with ready=0 is ignored; no state change, no pulse.
- Eligibility: valid & ~pending & ~wave_stop_fetch[i], excluding any slot named by a salu_branch_en this cycle.
- Fetch arbitration:
  - Round-robin starting at the pointer; one grant per cycle.
  - Registered outputs: buff_rd_en=1, buff_addr = pc, buff_tag = {epoch, slot} in the cycle after the grant.
  - The granted slot sets pending; the pointer moves to grant+1, wrapping NUM_WF-1 -> 0.
  - No eligible slot: buff_rd_en=0 and the pointer is held.
- Ack, with s = buff_ack_tag slot field:
  - Always clear pending[s].
  - If valid[s] and tag epoch == epoch[s]: pc[s] += FETCH_BYTES, modulo 2^PC_W wrap.
  - Otherwise: no PC change, fetch_discard=1 next cycle.
- Branch (salu_branch_en=1):
  - Not taken: no change, since the PC already advanced on its ack.
  - Taken: pc = target and epoch toggles, so any in-flight fetch for that slot becomes stale.
  - Taken branch and matching ack for the same slot in the same cycle: the branch wins, the ack is treated as stale, fetch_discard=1.
- Done (issue_wf_done_en=1):
  - Clear valid and toggle epoch.
  - Next cycle: cu2dispatch_wf_done=1 and cu2dispatch_wf_tag_done = stored tag.
  - A slot with pending=1 is not reallocated until its ack arrives; that ack is discarded.
- Simultaneous events:
  - Done and dispatch in the same cycle: the freed slot is not reused that cycle.
  - Done and grant on the same slot in the same cycle: grant suppressed.
- Events naming a slot >= NUM_WF are ignored.

Test Plan:
- Reset, then dispatch tag=5, pc=0x18 -> reserve pulse slot 0; buff_rd_en with addr 0x18, tag {0,0}; ack -> next fetch addr 0x1C.
- Dispatch 3 wavefronts, no acks, stop_fetch=0 -> grants to slots 0,1,2 in consecutive cycles; ack slot 1 -> next grant slot 1 only.
- Slot 0 fetch outstanding; taken branch to 0x30 -> ack tag {0,0} gives fetch_discard=1 and pc stays 0x30; next fetch addr 0x30, tag {1,0}.
- Fill all 40 slots -> cu2dispatch_ready=0 and a further dispatch is ignored; done on slot 7 (no pending) -> retire pulse with its tag; the next dispatch gets slot 7.
- Done on slot with pending fetch -> slot not allocatable until ack; ack gives fetch_discard=1, then ready=1.
- Assert rst=0 mid-fetch -> all outputs 0 immediately; no request after release until a new dispatch.

Source files
------------

// File: rtl/fetch_wf_sched.sv
// Wavefront PC table and round-robin fetch scheduler with epoch-tagged
// stale-fetch discard for branch redirects and wavefront retirement.
module fetch_wf_sched #(
    parameter int unsigned NUM_WF      = 40,
    parameter int unsigned WFID_W      = 6,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned TAG_W       = 15,
    parameter int unsigned FETCH_BYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dispatch2cu_wf_dispatch,
    input  logic [TAG_W-1:0]    dispatch2cu_wf_tag_dispatch,
    input  logic [PC_W-1:0]     dispatch2cu_start_pc_dispatch,
    output logic                cu2dispatch_ready,
    output logic                wave_reserve_valid,
    output logic [WFID_W-1:0]   wave_reserve_slotid,
    input  logic [NUM_WF-1:0]   wave_stop_fetch,
    output logic                buff_rd_en,
    output logic [PC_W-1:0]     buff_addr,
    output logic [WFID_W:0]     buff_tag,
    input  logic                buff_ack,
    input  logic [WFID_W:0]     buff_ack_tag,
    output logic                fetch_discard,
    input  logic                salu_branch_en,
    input  logic [WFID_W-1:0]   salu_branch_wfid,
    input  logic                salu_branch_taken,
    input  logic [PC_W-1:0]     salu_branch_pc_value,
    input  logic                issue_wf_done_en,
    input  logic [WFID_W-1:0]   issue_wf_done_wf_id,
    output logic                cu2dispatch_wf_done,
    output logic [TAG_W-1:0]    cu2dispatch_wf_tag_done
);

    // Per-slot state
    logic [NUM_WF-1:0]  valid_q, valid_d;
    logic [NUM_WF-1:0]  pending_q, pending_d;
    logic [NUM_WF-1:0]  epoch_q, epoch_d;
    logic [PC_W-1:0]    pc_q [NUM_WF];
    logic [PC_W-1:0]    pc_d [NUM_WF];
    logic [TAG_W-1:0]   tag_q [NUM_WF];
    logic [TAG_W-1:0]   tag_d [NUM_WF];
    logic [WFID_W-1:0]  rr_ptr_q, rr_ptr_d;

    // Registered outputs
    logic               reserve_valid_q;
    logic [WFID_W-1:0]  reserve_slotid_q;
    logic               rd_en_q;
    logic [PC_W-1:0]    addr_q;
    logic [WFID_W:0]    btag_q;
    logic               discard_q;
    logic               wf_done_q;
    logic [TAG_W-1:0]   wf_tag_done_q;

    // Event decode
    logic [WFID_W-1:0]  ack_slot_c;
    logic               ack_epoch_c;
    logic               ack_hit_c, ack_good_c, discard_c;
    logic               br_hit_c, br_take_c, done_hit_c;
    logic [NUM_WF-1:0]  allocable_c, elig_c;
    logic               alloc_c;
    logic [WFID_W-1:0]  alloc_id_c;
    logic               grant_vld_c;
    logic [WFID_W-1:0]  grant_id_c;

    assign ack_slot_c  = buff_ack_tag[WFID_W-1:0];
    assign ack_epoch_c = buff_ack_tag[WFID_W];
    assign ack_hit_c   = buff_ack && (32'(ack_slot_c) < NUM_WF);
    assign br_hit_c    = salu_branch_en && (32'(salu_branch_wfid) < NUM_WF);
    assign br_take_c   = br_hit_c && salu_branch_taken;
    assign done_hit_c  = issue_wf_done_en && (32'(issue_wf_done_wf_id) < NUM_WF);
    // A taken branch on the same slot makes an otherwise matching ack stale
    assign ack_good_c  = ack_hit_c && valid_q[ack_slot_c]
                         && (ack_epoch_c == epoch_q[ack_slot_c])
                         && !(br_take_c && (salu_branch_wfid == ack_slot_c));
    assign discard_c   = ack_hit_c && !ack_good_c;

    assign allocable_c       = ~valid_q & ~pending_q;
    assign cu2dispatch_ready = |allocable_c;
    assign alloc_c           = dispatch2cu_wf_dispatch && cu2dispatch_ready;

    // Lowest-index allocatable slot
    always_comb begin
        alloc_id_c = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (allocable_c[i]) alloc_id_c = WFID_W'(i);
        end
    end

    // Fetch eligibility; branch or done on a slot blocks its grant this cycle
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < NUM_WF; i++) begin
            elig_c[i] = valid_q[i] && !pending_q[i] && !wave_stop_fetch[i]
                        && !(br_hit_c && (32'(salu_branch_wfid) == i))
                        && !(done_hit_c && (32'(issue_wf_done_wf_id) == i));
        end
    end

    // Round-robin search starting at the pointer
    always_comb begin
        int unsigned idx;
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_WF; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_WF) idx = idx - NUM_WF;
            if (!grant_vld_c && elig_c[WFID_W'(idx)]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = WFID_W'(idx);
            end
        end
    end

    // Next-state for slot table and pointer
    always_comb begin
        valid_d   = valid_q;
        pending_d = pending_q;
        epoch_d   = epoch_q;
        pc_d      = pc_q;
        tag_d     = tag_q;
        rr_ptr_d  = rr_ptr_q;
        if (ack_hit_c) begin
            pending_d[ack_slot_c] = 1'b0;
            if (ack_good_c) pc_d[ack_slot_c] = pc_q[ack_slot_c] + PC_W'(FETCH_BYTES);
        end
        if (br_take_c) begin
            pc_d[salu_branch_wfid]    = salu_branch_pc_value;
            epoch_d[salu_branch_wfid] = ~epoch_q[salu_branch_wfid];
        end
        if (done_hit_c) begin
            valid_d[issue_wf_done_wf_id] = 1'b0;
            epoch_d[issue_wf_done_wf_id] = ~epoch_q[issue_wf_done_wf_id];
        end
        if (grant_vld_c) begin
            pending_d[grant_id_c] = 1'b1;
            rr_ptr_d = (32'(grant_id_c) == NUM_WF - 1) ? '0 : grant_id_c + WFID_W'(1);
        end
        if (alloc_c) begin
            valid_d[alloc_id_c] = 1'b1;
            pc_d[alloc_id_c]    = dispatch2cu_start_pc_dispatch;
            tag_d[alloc_id_c]   = dispatch2cu_wf_tag_dispatch;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q          <= '0;
            pending_q        <= '0;
            epoch_q          <= '0;
            rr_ptr_q         <= '0;
            for (int unsigned i = 0; i < NUM_WF; i++) begin
                pc_q[i]  <= '0;
                tag_q[i] <= '0;
            end
            reserve_valid_q  <= 1'b0;
            reserve_slotid_q <= '0;
            rd_en_q          <= 1'b0;
            addr_q           <= '0;
            btag_q           <= '0;
            discard_q        <= 1'b0;
            wf_done_q        <= 1'b0;
            wf_tag_done_q    <= '0;
        end else begin
            valid_q          <= valid_d;
            pending_q        <= pending_d;
            epoch_q          <= epoch_d;
            rr_ptr_q         <= rr_ptr_d;
            pc_q             <= pc_d;
            tag_q            <= tag_d;
            reserve_valid_q  <= alloc_c;
            if (alloc_c) reserve_slotid_q <= alloc_id_c;
            rd_en_q          <= grant_vld_c;
            if (grant_vld_c) begin
                addr_q <= pc_q[grant_id_c];
                btag_q <= {epoch_q[grant_id_c], grant_id_c};
            end
            discard_q        <= discard_c;
            wf_done_q        <= done_hit_c;
            if (done_hit_c) wf_tag_done_q <= tag_q[issue_wf_done_wf_id];
        end
    end

    assign wave_reserve_valid      = reserve_valid_q;
    assign wave_reserve_slotid     = reserve_slotid_q;
    assign buff_rd_en              = rd_en_q;
    assign buff_addr               = addr_q;
    assign buff_tag                = btag_q;
    assign fetch_discard           = discard_q;
    assign cu2dispatch_wf_done     = wf_done_q;
    assign cu2dispatch_wf_tag_done = wf_tag_done_q;

endmodule

// File: tb/tb_fetch_wf_sched.sv
// Directed self-checking bench for fetch_wf_sched.
module tb_fetch_wf_sched;

    logic        clk;
    logic        rst;
    logic        dispatch2cu_wf_dispatch;
    logic [14:0] dispatch2cu_wf_tag_dispatch;
    logic [31:0] dispatch2cu_start_pc_dispatch;
    logic        cu2dispatch_ready;
    logic        wave_reserve_valid;
    logic [5:0]  wave_reserve_slotid;
    logic [39:0] wave_stop_fetch;
    logic        buff_rd_en;
    logic [31:0] buff_addr;
    logic [6:0]  buff_tag;
    logic        buff_ack;
    logic [6:0]  buff_ack_tag;
    logic        fetch_discard;
    logic        salu_branch_en;
    logic [5:0]  salu_branch_wfid;
    logic        salu_branch_taken;
    logic [31:0] salu_branch_pc_value;
    logic        issue_wf_done_en;
    logic [5:0]  issue_wf_done_wf_id;
    logic        cu2dispatch_wf_done;
    logic [14:0] cu2dispatch_wf_tag_done;

    int checks = 0;
    int errors = 0;

    fetch_wf_sched dut (
        .clk                           (clk),
        .rst                           (rst),
        .dispatch2cu_wf_dispatch       (dispatch2cu_wf_dispatch),
        .dispatch2cu_wf_tag_dispatch   (dispatch2cu_wf_tag_dispatch),
        .dispatch2cu_start_pc_dispatch (dispatch2cu_start_pc_dispatch),
        .cu2dispatch_ready             (cu2dispatch_ready),
        .wave_reserve_valid            (wave_reserve_valid),
        .wave_reserve_slotid           (wave_reserve_slotid),
        .wave_stop_fetch               (wave_stop_fetch),
        .buff_rd_en                    (buff_rd_en),
        .buff_addr                     (buff_addr),
        .buff_tag                      (buff_tag),
        .buff_ack                      (buff_ack),
        .buff_ack_tag                  (buff_ack_tag),
        .fetch_discard                 (fetch_discard),
        .salu_branch_en                (salu_branch_en),
        .salu_branch_wfid              (salu_branch_wfid),
        .salu_branch_taken             (salu_branch_taken),
        .salu_branch_pc_value          (salu_branch_pc_value),
        .issue_wf_done_en              (issue_wf_done_en),
        .issue_wf_done_wf_id           (issue_wf_done_wf_id),
        .cu2dispatch_wf_done           (cu2dispatch_wf_done),
        .cu2dispatch_wf_tag_done       (cu2dispatch_wf_tag_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dispatch2cu_wf_dispatch       = 1'b0;
        dispatch2cu_wf_tag_dispatch   = '0;
        dispatch2cu_start_pc_dispatch = '0;
        wave_stop_fetch               = '0;
        buff_ack                      = 1'b0;
        buff_ack_tag                  = '0;
        salu_branch_en                = 1'b0;
        salu_branch_wfid              = '0;
        salu_branch_taken             = 1'b0;
        salu_branch_pc_value          = '0;
        issue_wf_done_en              = 1'b0;
        issue_wf_done_wf_id           = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic dispatch(input logic [14:0] tag, input logic [31:0] pc);
        dispatch2cu_wf_dispatch       = 1'b1;
        dispatch2cu_wf_tag_dispatch   = tag;
        dispatch2cu_start_pc_dispatch = pc;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if ({buff_rd_en, wave_reserve_valid, fetch_discard, cu2dispatch_wf_done} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000",
                {buff_rd_en, wave_reserve_valid, fetch_discard, cu2dispatch_wf_done});
        end
        checks++;
        if ({buff_addr, buff_tag, wave_reserve_slotid, cu2dispatch_wf_tag_done} !== '0) begin
            errors++; $display("FAIL reset_data: addr %h tag %h slot %h rtag %h expected all 0",
                buff_addr, buff_tag, wave_reserve_slotid, cu2dispatch_wf_tag_done);
        end
        checks++;
        if (cu2dispatch_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", cu2dispatch_ready);
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_basic_fetch();
        do_reset();
        dispatch(15'd5, 32'h18);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        checks++;
        if ({wave_reserve_valid, wave_reserve_slotid, buff_rd_en} !== {1'b1, 6'd0, 1'b0}) begin
            errors++; $display("FAIL basic_reserve: valid %b slot %0d rd %b expected 1 0 0",
                wave_reserve_valid, wave_reserve_slotid, buff_rd_en);
        end
        tick();
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag} !== {1'b1, 32'h18, 7'h00}) begin
            errors++; $display("FAIL basic_fetch: rd %b addr %h tag %h expected 1 18 00",
                buff_rd_en, buff_addr, buff_tag);
        end
        tick();
        checks++;
        if (buff_rd_en !== 1'b0) begin
            errors++; $display("FAIL basic_pending_hold: rd %b expected 0", buff_rd_en);
        end
        buff_ack = 1'b1; buff_ack_tag = 7'h00;
        tick();
        buff_ack = 1'b0;
        checks++;
        if ({fetch_discard, buff_rd_en} !== 2'b00) begin
            errors++; $display("FAIL basic_ack: discard %b rd %b expected 0 0", fetch_discard, buff_rd_en);
        end
        tick();
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag} !== {1'b1, 32'h1C, 7'h00}) begin
            errors++; $display("FAIL basic_next_fetch: rd %b addr %h tag %h expected 1 1c 00",
                buff_rd_en, buff_addr, buff_tag);
        end
    endtask

    task automatic test_round_robin();
        logic [5:0]  exp_slot [3];
        logic [31:0] exp_pc   [3];
        exp_slot[0] = 6'd0; exp_slot[1] = 6'd1; exp_slot[2] = 6'd2;
        exp_pc[0] = 32'h100; exp_pc[1] = 32'h200; exp_pc[2] = 32'h300;
        do_reset();
        wave_stop_fetch = '1;
        for (int i = 0; i < 3; i++) begin
            dispatch(15'(20 + i), exp_pc[i]);
            tick();
            checks++;
            if ({wave_reserve_valid, wave_reserve_slotid} !== {1'b1, exp_slot[i]}) begin
                errors++; $display("FAIL rr_reserve%0d: valid %b slot %0d expected 1 %0d",
                    i, wave_reserve_valid, wave_reserve_slotid, exp_slot[i]);
            end
        end
        dispatch2cu_wf_dispatch = 1'b0;
        wave_stop_fetch = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({buff_rd_en, buff_tag, buff_addr} !== {1'b1, 1'b0, exp_slot[i], exp_pc[i]}) begin
                errors++; $display("FAIL rr_grant%0d: rd %b tag %h addr %h expected 1 %h %h",
                    i, buff_rd_en, buff_tag, buff_addr, exp_slot[i], exp_pc[i]);
            end
        end
        tick();
        checks++;
        if (buff_rd_en !== 1'b0) begin
            errors++; $display("FAIL rr_all_pending: rd %b expected 0", buff_rd_en);
        end
        buff_ack = 1'b1; buff_ack_tag = 7'h01;
        tick();
        buff_ack = 1'b0;
        checks++;
        if (buff_rd_en !== 1'b0) begin
            errors++; $display("FAIL rr_ack_cycle: rd %b expected 0", buff_rd_en);
        end
        tick();
        checks++;
        if ({buff_rd_en, buff_tag, buff_addr} !== {1'b1, 7'h01, 32'h204}) begin
            errors++; $display("FAIL rr_regrant: rd %b tag %h addr %h expected 1 01 204",
                buff_rd_en, buff_tag, buff_addr);
        end
        tick();
        checks++;
        if (buff_rd_en !== 1'b0) begin
            errors++; $display("FAIL rr_only_one: rd %b expected 0", buff_rd_en);
        end
    endtask

    task automatic test_branch();
        do_reset();
        dispatch(15'd9, 32'h10);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        tick();
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag} !== {1'b1, 32'h10, 7'h00}) begin
            errors++; $display("FAIL br_first_fetch: rd %b addr %h tag %h expected 1 10 00",
                buff_rd_en, buff_addr, buff_tag);
        end
        salu_branch_en = 1'b1; salu_branch_wfid = 6'd0; salu_branch_taken = 1'b1;
        salu_branch_pc_value = 32'h30;
        tick();
        salu_branch_en = 1'b0;
        buff_ack = 1'b1; buff_ack_tag = 7'h00;
        tick();
        buff_ack = 1'b0;
        checks++;
        if ({fetch_discard, buff_rd_en} !== 2'b10) begin
            errors++; $display("FAIL br_stale_discard: discard %b rd %b expected 1 0", fetch_discard, buff_rd_en);
        end
        tick();
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag, fetch_discard} !== {1'b1, 32'h30, 7'h40, 1'b0}) begin
            errors++; $display("FAIL br_redirect_fetch: rd %b addr %h tag %h discard %b expected 1 30 40 0",
                buff_rd_en, buff_addr, buff_tag, fetch_discard);
        end
        // taken branch and matching ack in the same cycle: branch wins
        salu_branch_en = 1'b1; salu_branch_wfid = 6'd0; salu_branch_taken = 1'b1;
        salu_branch_pc_value = 32'h80;
        buff_ack = 1'b1; buff_ack_tag = 7'h40;
        tick();
        salu_branch_en = 1'b0; buff_ack = 1'b0;
        checks++;
        if (fetch_discard !== 1'b1) begin
            errors++; $display("FAIL br_same_cycle_discard: discard %b expected 1", fetch_discard);
        end
        tick();
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag} !== {1'b1, 32'h80, 7'h00}) begin
            errors++; $display("FAIL br_same_cycle_fetch: rd %b addr %h tag %h expected 1 80 00",
                buff_rd_en, buff_addr, buff_tag);
        end
        // not-taken branch alongside a good ack: pc advances normally
        salu_branch_en = 1'b1; salu_branch_wfid = 6'd0; salu_branch_taken = 1'b0;
        salu_branch_pc_value = 32'hDEAD;
        buff_ack = 1'b1; buff_ack_tag = 7'h00;
        tick();
        salu_branch_en = 1'b0; buff_ack = 1'b0;
        checks++;
        if (fetch_discard !== 1'b0) begin
            errors++; $display("FAIL br_not_taken_ack: discard %b expected 0", fetch_discard);
        end
        tick();
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag} !== {1'b1, 32'h84, 7'h00}) begin
            errors++; $display("FAIL br_not_taken_fetch: rd %b addr %h tag %h expected 1 84 00",
                buff_rd_en, buff_addr, buff_tag);
        end
    endtask

    task automatic test_fill_and_retire();
        do_reset();
        wave_stop_fetch = '1;
        for (int i = 0; i < 40; i++) begin
            dispatch(15'(100 + i), 32'(i * 16));
            tick();
            checks++;
            if ({wave_reserve_valid, wave_reserve_slotid} !== {1'b1, 6'(i)}) begin
                errors++; $display("FAIL fill_slot%0d: valid %b slot %0d expected 1 %0d",
                    i, wave_reserve_valid, wave_reserve_slotid, i);
            end
        end
        dispatch2cu_wf_dispatch = 1'b0;
        checks++;
        if (cu2dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL fill_ready_low: ready %b expected 0", cu2dispatch_ready);
        end
        dispatch(15'd999, 32'hFFF0);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        checks++;
        if (wave_reserve_valid !== 1'b0) begin
            errors++; $display("FAIL fill_ignored_dispatch: valid %b expected 0", wave_reserve_valid);
        end
        issue_wf_done_en = 1'b1; issue_wf_done_wf_id = 6'd7;
        tick();
        issue_wf_done_en = 1'b0;
        checks++;
        if ({cu2dispatch_wf_done, cu2dispatch_wf_tag_done} !== {1'b1, 15'd107}) begin
            errors++; $display("FAIL retire7: done %b tag %0d expected 1 107",
                cu2dispatch_wf_done, cu2dispatch_wf_tag_done);
        end
        checks++;
        if (cu2dispatch_ready !== 1'b1) begin
            errors++; $display("FAIL retire7_ready: ready %b expected 1", cu2dispatch_ready);
        end
        dispatch(15'd500, 32'h700);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        checks++;
        if ({wave_reserve_valid, wave_reserve_slotid} !== {1'b1, 6'd7}) begin
            errors++; $display("FAIL refill7: valid %b slot %0d expected 1 7",
                wave_reserve_valid, wave_reserve_slotid);
        end
        // done and dispatch together while full: freed slot not reused this cycle
        issue_wf_done_en = 1'b1; issue_wf_done_wf_id = 6'd3;
        dispatch(15'd600, 32'h600);
        tick();
        issue_wf_done_en = 1'b0;
        checks++;
        if ({cu2dispatch_wf_done, cu2dispatch_wf_tag_done, wave_reserve_valid} !== {1'b1, 15'd103, 1'b0}) begin
            errors++; $display("FAIL done_dispatch_same: done %b tag %0d reserve %b expected 1 103 0",
                cu2dispatch_wf_done, cu2dispatch_wf_tag_done, wave_reserve_valid);
        end
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        checks++;
        if ({wave_reserve_valid, wave_reserve_slotid} !== {1'b1, 6'd3}) begin
            errors++; $display("FAIL refill3: valid %b slot %0d expected 1 3",
                wave_reserve_valid, wave_reserve_slotid);
        end
        wave_stop_fetch = ~(40'd1 << 7);
        tick();
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag} !== {1'b1, 32'h700, 7'h47}) begin
            errors++; $display("FAIL refill7_fetch: rd %b addr %h tag %h expected 1 700 47",
                buff_rd_en, buff_addr, buff_tag);
        end
    endtask

    task automatic test_done_pending();
        do_reset();
        dispatch(15'd11, 32'h40);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        tick();
        checks++;
        if ({buff_rd_en, buff_addr} !== {1'b1, 32'h40}) begin
            errors++; $display("FAIL dp_fetch: rd %b addr %h expected 1 40", buff_rd_en, buff_addr);
        end
        wave_stop_fetch = '1;
        issue_wf_done_en = 1'b1; issue_wf_done_wf_id = 6'd0;
        tick();
        issue_wf_done_en = 1'b0;
        checks++;
        if ({cu2dispatch_wf_done, cu2dispatch_wf_tag_done} !== {1'b1, 15'd11}) begin
            errors++; $display("FAIL dp_retire: done %b tag %0d expected 1 11",
                cu2dispatch_wf_done, cu2dispatch_wf_tag_done);
        end
        dispatch(15'd12, 32'h50);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        checks++;
        if ({wave_reserve_valid, wave_reserve_slotid} !== {1'b1, 6'd1}) begin
            errors++; $display("FAIL dp_skip_pending: valid %b slot %0d expected 1 1",
                wave_reserve_valid, wave_reserve_slotid);
        end
        buff_ack = 1'b1; buff_ack_tag = 7'h00;
        tick();
        buff_ack = 1'b0;
        checks++;
        if (fetch_discard !== 1'b1) begin
            errors++; $display("FAIL dp_discard: discard %b expected 1", fetch_discard);
        end
        dispatch(15'd13, 32'h60);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        checks++;
        if ({wave_reserve_valid, wave_reserve_slotid} !== {1'b1, 6'd0}) begin
            errors++; $display("FAIL dp_realloc: valid %b slot %0d expected 1 0",
                wave_reserve_valid, wave_reserve_slotid);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        wave_stop_fetch = '1;
        issue_wf_done_en = 1'b1; issue_wf_done_wf_id = 6'd45;
        buff_ack = 1'b1; buff_ack_tag = 7'h2D;
        tick();
        issue_wf_done_en = 1'b0; buff_ack = 1'b0;
        checks++;
        if ({cu2dispatch_wf_done, fetch_discard} !== 2'b00) begin
            errors++; $display("FAIL oor_ignored: done %b discard %b expected 0 0",
                cu2dispatch_wf_done, fetch_discard);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        dispatch(15'd33, 32'h90);
        tick();
        dispatch2cu_wf_dispatch = 1'b0;
        tick();
        checks++;
        if ({buff_rd_en, buff_addr} !== {1'b1, 32'h90}) begin
            errors++; $display("FAIL rm_fetch: rd %b addr %h expected 1 90", buff_rd_en, buff_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({buff_rd_en, buff_addr, buff_tag, wave_reserve_valid, cu2dispatch_ready} !== {1'b0, 32'h0, 7'h0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rm_async_clear: rd %b addr %h tag %h reserve %b ready %b expected 0 0 0 0 1",
                buff_rd_en, buff_addr, buff_tag, wave_reserve_valid, cu2dispatch_ready);
        end
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (buff_rd_en !== 1'b0) begin
                errors++; $display("FAIL rm_idle%0d: rd %b expected 0", i, buff_rd_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_round_robin();
        test_branch();
        test_fill_and_retire();
        test_done_pending();
        test_out_of_range();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
